io_regfile: RTL and testbench

Parametrised processor register file with hardware-mapped I/O channels for the Tetris CPU. It replaces the fixed 32x32 file that had a hard-coded shape and change-shape register pair. The block provides two read ports, one write port and optional write-to-read bypass. It also maps a configurable set of registers as event-capture inputs, with pending/overrun tracking, and as exported outputs. It sits between the decode/writeback stages and the game-logic hardware (shape generator, input controller, VGA state).

---
 rtl/io_regfile_if.sv | 21 ++
 rtl/io_regfile.sv | 71 +++++++
 tb/tb_io_regfile.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/io_regfile_if.sv
// io_regfile_if: software-side register file bus, one write port and two combinational read ports.
interface io_regfile_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              ctrl_writeEnable;
  logic [ADDR_W-1:0] ctrl_writeReg;
  logic [DATA_W-1:0] data_writeReg;
  logic [ADDR_W-1:0] ctrl_readRegA;
  logic [ADDR_W-1:0] ctrl_readRegB;
  logic [DATA_W-1:0] data_readRegA;
  logic [DATA_W-1:0] data_readRegB;
  modport master (
    output ctrl_writeEnable, ctrl_writeReg, data_writeReg, ctrl_readRegA, ctrl_readRegB,
    input  data_readRegA, data_readRegB
  );
  modport slave (
    input  ctrl_writeEnable, ctrl_writeReg, data_writeReg, ctrl_readRegA, ctrl_readRegB,
    output data_readRegA, data_readRegB
  );
endinterface

// File: rtl/io_regfile.sv
// io_regfile: register file with event-capture input channels, exported output registers and optional write bypass.
module io_regfile #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int IN_BASE  = 2,
  parameter int NUM_IN   = 1,
  parameter int OUT_BASE = 1,
  parameter int NUM_OUT  = 1,
  parameter int BYPASS   = 1
) (
  input  logic                      clock,
  input  logic                      ctrl_reset,
  io_regfile_if.slave               bus,
  input  logic [NUM_IN-1:0]         hw_event,
  input  logic [NUM_IN*DATA_W-1:0]  hw_value,
  output logic [NUM_OUT*DATA_W-1:0] out_regs,
  output logic [NUM_IN-1:0]         event_pending,
  output logic [NUM_IN-1:0]         event_overrun
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] IN_LO = (ADDR_W+1)'(IN_BASE);
  localparam logic [ADDR_W:0] IN_HI = (ADDR_W+1)'(IN_BASE + NUM_IN);
  if (IN_BASE < 1 || OUT_BASE < 1 || NUM_IN < 1 || NUM_OUT < 1 ||
      IN_BASE + NUM_IN > DEPTH || OUT_BASE + NUM_OUT > DEPTH ||
      !(IN_BASE + NUM_IN <= OUT_BASE || OUT_BASE + NUM_OUT <= IN_BASE)) begin : g_bad_map
    $error("io_regfile: invalid input/output channel address map");
  end
  logic [DATA_W-1:0] regs [1:DEPTH-1];
  function automatic logic is_in(input logic [ADDR_W-1:0] a);
    return {1'b0, a} >= IN_LO && {1'b0, a} < IN_HI;
  endfunction
  for (genvar a = 1; a < DEPTH; a++) begin : g_reg
    localparam logic [ADDR_W-1:0] A = ADDR_W'(a);
    logic hit;
    assign hit = bus.ctrl_writeEnable && bus.ctrl_writeReg == A;
    if (a >= IN_BASE && a < IN_BASE + NUM_IN) begin : g_in
      localparam int C = a - IN_BASE;
      // A capture beats a same-edge acknowledge so that no hardware event is lost.
      always_ff @(posedge clock or posedge ctrl_reset)
        if (ctrl_reset) begin
          regs[a]          <= '0;
          event_pending[C] <= 1'b0;
          event_overrun[C] <= 1'b0;
        end else if (hw_event[C]) begin
          regs[a]          <= hw_value[C*DATA_W +: DATA_W];
          event_pending[C] <= 1'b1;
          if (event_pending[C] && !hit) event_overrun[C] <= 1'b1;
        end else if (hit) begin
          regs[a]          <= bus.data_writeReg;
          event_pending[C] <= 1'b0;
          event_overrun[C] <= 1'b0;
        end
    end else begin : g_gen
      always_ff @(posedge clock or posedge ctrl_reset)
        if (ctrl_reset) regs[a] <= '0;
        else if (hit) regs[a] <= bus.data_writeReg;
    end
  end
  for (genvar o = 0; o < NUM_OUT; o++) begin : g_out
    assign out_regs[o*DATA_W +: DATA_W] = regs[OUT_BASE + o];
  end
  logic byp_a, byp_b;
  always_comb begin
    byp_a = BYPASS != 0 && !ctrl_reset && bus.ctrl_writeEnable &&
            bus.ctrl_writeReg == bus.ctrl_readRegA && !is_in(bus.ctrl_readRegA);
    byp_b = BYPASS != 0 && !ctrl_reset && bus.ctrl_writeEnable &&
            bus.ctrl_writeReg == bus.ctrl_readRegB && !is_in(bus.ctrl_readRegB);
    bus.data_readRegA = bus.ctrl_readRegA == '0 ? '0 : byp_a ? bus.data_writeReg : regs[bus.ctrl_readRegA];
    bus.data_readRegB = bus.ctrl_readRegB == '0 ? '0 : byp_b ? bus.data_writeReg : regs[bus.ctrl_readRegB];
  end
endmodule

// File: tb/tb_io_regfile.sv
// tb_io_regfile: random and directed checks of two io_regfile configurations against an array-based reference model.
module tb_io_regfile;
  logic clock = 1'b0;
  logic ctrl_reset = 1'b1;
  always #5 clock = ~clock;
  io_regfile_if #(.DATA_W(32), .ADDR_W(5)) bus0 ();
  io_regfile_if #(.DATA_W(16), .ADDR_W(4)) bus1 ();
  logic        ev0, p0, o0;
  logic [31:0] hv0, out0;
  logic [1:0]  ev1, p1, o1;
  logic [31:0] hv1, out1;
  io_regfile dut0 (
    .clock(clock), .ctrl_reset(ctrl_reset), .bus(bus0.slave), .hw_event(ev0), .hw_value(hv0),
    .out_regs(out0), .event_pending(p0), .event_overrun(o0)
  );
  io_regfile #(.DATA_W(16), .ADDR_W(4), .IN_BASE(2), .NUM_IN(2), .OUT_BASE(5), .NUM_OUT(2), .BYPASS(0)) dut1 (
    .clock(clock), .ctrl_reset(ctrl_reset), .bus(bus1.slave), .hw_event(ev1), .hw_value(hv1),
    .out_regs(out1), .event_pending(p1), .event_overrun(o1)
  );
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] mreg [2][32];
  logic [1:0]  mpend [2];
  logic [1:0]  movr [2];
  logic [31:0] v;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic int nin(input int d);
    return d == 0 ? 1 : 2;
  endfunction
  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      for (int a = 0; a < 32; a++) mreg[d][a] = '0;
      mpend[d] = '0;
      movr[d]  = '0;
    end
  endtask
  // Config 0 bypasses general registers; config 1 never bypasses. Channels start at address 2 in both.
  function automatic logic [31:0] exp_rd(input int d, input logic [31:0] a, input logic we,
                                        input logic [31:0] wr, input logic [31:0] wd);
    if (ctrl_reset || a == 0) return '0;
    if (d == 0 && we && wr == a && !(a >= 2 && a < 32'(2 + nin(d)))) return wd;
    return mreg[d][a[4:0]];
  endfunction
  task automatic model_step(input int d, input logic we, input logic [31:0] wr, input logic [31:0] wd,
                            input logic [1:0] ev, input logic [31:0] hv);
    logic [1:0] p;
    logic sw;
    p = mpend[d];
    if (we && wr != 0) mreg[d][wr[4:0]] = wd;
    for (int c = 0; c < nin(d); c++) begin
      sw = we && wr == 32'(2 + c);
      if (ev[c]) begin
        mreg[d][2 + c] = d == 0 ? hv : 32'(hv[c*16 +: 16]);
        if (p[c] && !sw) movr[d][c] = 1'b1;
        mpend[d][c] = 1'b1;
      end else if (sw) begin
        mpend[d][c] = 1'b0;
        movr[d][c]  = 1'b0;
      end
    end
  endtask
  task automatic check_all();
    #1;
    check("d0 rdA", bus0.data_readRegA, exp_rd(0, 32'(bus0.ctrl_readRegA), bus0.ctrl_writeEnable,
          32'(bus0.ctrl_writeReg), bus0.data_writeReg));
    check("d0 rdB", bus0.data_readRegB, exp_rd(0, 32'(bus0.ctrl_readRegB), bus0.ctrl_writeEnable,
          32'(bus0.ctrl_writeReg), bus0.data_writeReg));
    check("d0 out", out0, mreg[0][1]);
    check("d0 pend", 32'(p0), 32'(mpend[0][0]));
    check("d0 ovr", 32'(o0), 32'(movr[0][0]));
    check("d1 rdA", 32'(bus1.data_readRegA), exp_rd(1, 32'(bus1.ctrl_readRegA), bus1.ctrl_writeEnable,
          32'(bus1.ctrl_writeReg), 32'(bus1.data_writeReg)));
    check("d1 rdB", 32'(bus1.data_readRegB), exp_rd(1, 32'(bus1.ctrl_readRegB), bus1.ctrl_writeEnable,
          32'(bus1.ctrl_writeReg), 32'(bus1.data_writeReg)));
    check("d1 out", out1, {mreg[1][6][15:0], mreg[1][5][15:0]});
    check("d1 pend", 32'(p1), 32'(mpend[1]));
    check("d1 ovr", 32'(o1), 32'(movr[1]));
  endtask
  task automatic tick();
    check_all();
    @(posedge clock);
    if (!ctrl_reset) begin
      model_step(0, bus0.ctrl_writeEnable, 32'(bus0.ctrl_writeReg), bus0.data_writeReg, {1'b0, ev0}, hv0);
      model_step(1, bus1.ctrl_writeEnable, 32'(bus1.ctrl_writeReg), 32'(bus1.data_writeReg), ev1, hv1);
    end
    @(negedge clock);
  endtask
  task automatic idle();
    bus0.ctrl_writeEnable = 1'b0;
    bus1.ctrl_writeEnable = 1'b0;
    ev0 = 1'b0;
    ev1 = 2'b00;
  endtask
  task automatic w0(input logic [4:0] a, input logic [31:0] d);
    bus0.ctrl_writeEnable = 1'b1;
    bus0.ctrl_writeReg    = a;
    bus0.data_writeReg    = d;
    tick();
    bus0.ctrl_writeEnable = 1'b0;
  endtask
  task automatic peek0(input logic [4:0] a, output logic [31:0] d);
    bus0.ctrl_readRegA = a;
    #1;
    d = bus0.data_readRegA;
  endtask
  task automatic rand_in();
    bus0.ctrl_writeEnable = 1'($urandom_range(0, 1));
    bus0.ctrl_writeReg    = $urandom_range(0, 3) == 0 ? 5'd2 : 5'($urandom_range(0, 31));
    bus0.data_writeReg    = $urandom;
    bus0.ctrl_readRegA    = $urandom_range(0, 2) == 0 ? bus0.ctrl_writeReg : 5'($urandom_range(0, 31));
    bus0.ctrl_readRegB    = 5'($urandom_range(0, 31));
    ev0 = $urandom_range(0, 3) == 0;
    hv0 = $urandom;
    bus1.ctrl_writeEnable = 1'($urandom_range(0, 1));
    bus1.ctrl_writeReg    = $urandom_range(0, 3) == 0 ? 4'(2 + $urandom_range(0, 1)) : 4'($urandom_range(0, 15));
    bus1.data_writeReg    = 16'($urandom);
    bus1.ctrl_readRegA    = $urandom_range(0, 2) == 0 ? bus1.ctrl_writeReg : 4'($urandom_range(0, 15));
    bus1.ctrl_readRegB    = 4'($urandom_range(0, 15));
    ev1 = 2'($urandom_range(0, 3)) & 2'($urandom_range(0, 3));
    hv1 = $urandom;
  endtask
  initial begin
    model_clear();
    idle();
    hv0 = '0;
    hv1 = '0;
    bus0.ctrl_writeReg = '0; bus0.data_writeReg = '0; bus0.ctrl_readRegA = '0; bus0.ctrl_readRegB = '0;
    bus1.ctrl_writeReg = '0; bus1.data_writeReg = '0; bus1.ctrl_readRegA = '0; bus1.ctrl_readRegB = '0;
    repeat (2) @(negedge clock);
    ctrl_reset = 1'b0;
    tick();
    // Preload, then a mid-cycle reset must clear registers, exports and pending flags at once.
    w0(5'd1, 32'h77);
    ev0 = 1'b1; hv0 = 32'h11;
    w0(5'd5, 32'hDEAD);
    ev0 = 1'b0;
    peek0(5'd5, v);
    check("preload r5", v, 32'hDEAD);
    check("preload pend", 32'(p0), 32'd1);
    #2;
    ctrl_reset = 1'b1;
    model_clear();
    peek0(5'd5, v);
    check("reset r5", v, 32'h0);
    check("reset out", out0, 32'h0);
    check("reset pend", 32'(p0), 32'h0);
    check_all();
    @(negedge clock);
    ctrl_reset = 1'b0;
    tick();
    w0(5'd0, 32'h1234);
    peek0(5'd0, v);
    check("r0 zero", v, 32'h0);
    bus0.ctrl_writeEnable = 1'b1; bus0.ctrl_writeReg = 5'd7; bus0.data_writeReg = 32'hABCD;
    bus1.ctrl_writeEnable = 1'b1; bus1.ctrl_writeReg = 4'd7; bus1.data_writeReg = 16'hBEEF;
    bus1.ctrl_readRegA = 4'd7;
    peek0(5'd7, v);
    check("bypass r7", v, 32'hABCD);
    check("nobypass r7", 32'(bus1.data_readRegA), 32'h0);
    tick();
    idle();
    #1;
    check("nobypass r7 after", 32'(bus1.data_readRegA), 32'hBEEF);
    ev0 = 1'b1; hv0 = 32'h5;
    tick();
    ev0 = 1'b0;
    peek0(5'd2, v);
    check("capture r2", v, 32'h5);
    check("capture pend", 32'(p0), 32'd1);
    w0(5'd2, 32'h0);
    peek0(5'd2, v);
    check("ack r2", v, 32'h0);
    check("ack pend", 32'(p0), 32'd0);
    ev0 = 1'b1; hv0 = 32'h3;
    tick();
    hv0 = 32'h4;
    tick();
    ev0 = 1'b0;
    peek0(5'd2, v);
    check("overrun r2", v, 32'h4);
    check("overrun flag", 32'(o0), 32'd1);
    w0(5'd2, 32'h0);
    check("overrun ack pend", 32'(p0), 32'd0);
    check("overrun ack ovr", 32'(o0), 32'd0);
    ev0 = 1'b1; hv0 = 32'h9;
    w0(5'd2, 32'h0);
    ev0 = 1'b0;
    peek0(5'd2, v);
    check("collision r2", v, 32'h9);
    check("collision pend", 32'(p0), 32'd1);
    w0(5'd2, 32'h0);
    w0(5'd1, 32'h6);
    check("export r1", out0, 32'h6);
    ev1 = 2'b10; hv1 = {16'h0077, 16'h0000};
    tick();
    ev1 = 2'b00;
    bus1.ctrl_readRegA = 4'd3; bus1.ctrl_readRegB = 4'd2;
    #1;
    check("ch1 r3", 32'(bus1.data_readRegA), 32'h77);
    check("ch1 r2 untouched", 32'(bus1.data_readRegB), 32'h0);
    check("ch1 pend", 32'(p1), 32'h2);
    bus1.ctrl_writeEnable = 1'b1; bus1.ctrl_writeReg = 4'd6; bus1.data_writeReg = 16'h1234;
    tick();
    idle();
    check("d1 export r6", 32'(out1[31:16]), 32'h1234);
    repeat (3000) begin
      rand_in();
      tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
